// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared register-file widths and types
package reg_pkg;

    localparam int REG_DATA_WIDTH_POW = 6;
    localparam int REG_MEM_DEPTH_POW  = 5;
    localparam int DW                 = 1 << REG_DATA_WIDTH_POW;
    localparam int NREG               = 1 << REG_MEM_DEPTH_POW;

    typedef logic [REG_MEM_DEPTH_POW-1:0] reg_idx_t;
    typedef logic [DW-1:0]                reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with rotating priority pointer
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      ptr
);

    logic [PW-1:0] idx;
    logic [PW-1:0] win_idx;
    logic          found;

    // Search from ptr+1 with wrap; the first valid requester wins, nothing during reset
    always_comb begin
        grant   = '0;
        win_idx = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win_idx    = idx;
                found      = 1'b1;
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    // Pointer follows the last winner so it drops to lowest priority next cycle
    always_ff @(posedge clk_in) begin
        if (reset) begin
            ptr <= PW'(NUM_REQ - 1);
        end else if (en) begin
            ptr <= win_idx;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - writeback port arbiter with pending-write scoreboard
module reg_wb_arbiter #(
    parameter int NUM_REQ            = 3,
    parameter int REG_DATA_WIDTH_POW = reg_pkg::REG_DATA_WIDTH_POW,
    parameter int REG_MEM_DEPTH_POW  = reg_pkg::REG_MEM_DEPTH_POW
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset,
    input  logic [NUM_REQ-1:0]                                   req_valid,
    input  logic [NUM_REQ-1:0][REG_MEM_DEPTH_POW-1:0]            req_rd,
    input  logic [NUM_REQ-1:0][(1 << REG_DATA_WIDTH_POW)-1:0]    req_data,
    output logic [NUM_REQ-1:0]                                   req_ready,
    input  logic                                                 reserve_en,
    input  logic [REG_MEM_DEPTH_POW-1:0]                         reserve_rd,
    output logic [(1 << REG_MEM_DEPTH_POW)-1:0]                  busy_out,
    output logic                                                 rf_write_en,
    output logic [REG_MEM_DEPTH_POW-1:0]                         rf_rd,
    output logic [(1 << REG_DATA_WIDTH_POW)-1:0]                 rf_data_write
);

    localparam int WB_DW   = 1 << REG_DATA_WIDTH_POW;
    localparam int WB_NREG = 1 << REG_MEM_DEPTH_POW;
    localparam int ARB_PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    import reg_pkg::*;

    logic [NUM_REQ-1:0]           grant;
    logic [ARB_PW-1:0]            arb_ptr;
    logic                         xfer;
    logic [REG_MEM_DEPTH_POW-1:0] sel_rd;
    logic [WB_DW-1:0]             sel_data;
    logic                         we_q;
    logic [REG_MEM_DEPTH_POW-1:0] rd_q;
    logic [WB_DW-1:0]             data_q;
    logic [WB_NREG-1:0]           busy_q;
    logic [WB_NREG-1:0]           busy_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk_in (clk_in),
        .reset  (reset),
        .req    (req_valid),
        .en     (xfer),
        .grant  (grant),
        .ptr    (arb_ptr)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // The priority pointer must always name a real requester
    always_comb begin
        assert (reset || (int'(arb_ptr) < NUM_REQ));
    end

    // Steer the granted requester's destination and data to the output register
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i];
                sel_data = req_data[i];
            end
        end
    end

    // Capture the winning write; x0 targets complete the handshake but never write
    always_ff @(posedge clk_in) begin
        if (reset) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (xfer) begin
            we_q   <= (sel_rd != '0);
            rd_q   <= sel_rd;
            data_q <= sel_data;
        end else begin
            we_q   <= 1'b0;
        end
    end

    // A write still in flight when reset is sampled must not reach the register file
    assign rf_write_en   = we_q & ~reset;
    assign rf_rd         = rd_q;
    assign rf_data_write = data_q;

    // Commit clears, reserve sets afterwards so a new producer wins a same-cycle collision
    always_comb begin
        busy_next = busy_q;
        if (rf_write_en) begin
            busy_next[rd_q] = 1'b0;
        end
        if (reserve_en && (reserve_rd != '0)) begin
            busy_next[reserve_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk_in) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_out = busy_q;

endmodule
